// File: rtl/e_mdu_if.sv
// Operand/result bundle between the E stage and the multiply/divide unit.
// The E stage (master) drives the op and operands; the MDU (slave) returns Busy, HI/LO and the read result.
interface e_mdu_if;
    logic        Start;
    logic [3:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDUOut;

    modport master (
        output Start, MDUOp, A, B,
        input  Busy, HI, LO, MDUOut
    );

    modport slave (
        input  Start, MDUOp, A, B,
        output Busy, HI, LO, MDUOut
    );
endinterface

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: the result is computed at Start into shadow registers
// and committed to HI/LO after a fixed Busy latency.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic    clk,
    input  logic    reset,
    e_mdu_if.slave  mdu
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [31:0]     hi_q, lo_q, sh_q, sl_q;
    logic            dz_q;

    logic [31:0]     sh_d, sl_d;
    logic            dz_d;
    logic [CW-1:0]   cnt_d;
    logic            md_start;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               div_signed, a_neg, b_neg;
    logic [31:0]        a_mag, b_mag, q_mag, r_mag;

    assign prod_s = $signed({{32{mdu.A[31]}}, mdu.A}) * $signed({{32{mdu.B[31]}}, mdu.B});
    assign prod_u = {32'd0, mdu.A} * {32'd0, mdu.B};

    // One unsigned divider serves both div and divu; signed div works on magnitudes
    // and fixes the signs afterwards, which also yields 0x80000000 / -1 = 0x80000000.
    assign div_signed = (mdu.MDUOp == OP_DIV);
    assign a_neg      = div_signed & mdu.A[31];
    assign b_neg      = div_signed & mdu.B[31];
    assign a_mag      = a_neg ? (32'd0 - mdu.A) : mdu.A;
    assign b_mag      = (mdu.B == 32'd0) ? 32'd1 : (b_neg ? (32'd0 - mdu.B) : mdu.B);
    assign q_mag      = a_mag / b_mag;
    assign r_mag      = a_mag % b_mag;

    assign md_start = mdu.Start && (mdu.MDUOp >= OP_MULT) && (mdu.MDUOp <= OP_DIVU);

    always_comb begin
        sh_d  = 32'd0;
        sl_d  = 32'd0;
        dz_d  = 1'b0;
        cnt_d = CW'(MULT_CYCLES);
        case (mdu.MDUOp)
            OP_MULT: begin
                sh_d = prod_s[63:32];
                sl_d = prod_s[31:0];
            end
            OP_MULTU: begin
                sh_d = prod_u[63:32];
                sl_d = prod_u[31:0];
            end
            OP_DIV, OP_DIVU: begin
                sl_d  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
                sh_d  = a_neg ? (32'd0 - r_mag) : r_mag;
                dz_d  = (mdu.B == 32'd0);
                cnt_d = CW'(DIV_CYCLES);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            sh_q    <= 32'd0;
            sl_q    <= 32'd0;
            dz_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (md_start) begin
                        sh_q    <= sh_d;
                        sl_q    <= sl_d;
                        dz_q    <= dz_d;
                        cnt_q   <= cnt_d;
                        state_q <= RUN;
                    end else if (!mdu.Start && mdu.MDUOp == OP_MTHI) begin
                        hi_q <= mdu.A;
                    end else if (!mdu.Start && mdu.MDUOp == OP_MTLO) begin
                        lo_q <= mdu.A;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        // Divide by zero still burns the full latency but leaves HI/LO alone.
                        if (!dz_q) begin
                            hi_q <= sh_q;
                            lo_q <= sl_q;
                        end
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mdu.Busy   = (state_q == RUN);
    assign mdu.HI     = hi_q;
    assign mdu.LO     = lo_q;
    assign mdu.MDUOut = (mdu.MDUOp == OP_MFHI) ? hi_q :
                        (mdu.MDUOp == OP_MFLO) ? lo_q : 32'd0;
endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: stimulus pushes expected HI/LO and latency, a monitor
// checks them when Busy falls.
module tb_e_mdu;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    e_mdu_if mif ();

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (mif.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int          cycles;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // Monitor: count Busy cycles, check HI/LO hold while busy, compare on Busy falling.
    initial begin : monitor
        logic prev_busy;
        logic prev_rst;
        int   bcnt;
        exp_t e;
        prev_busy = 1'b0;
        prev_rst  = 1'b1;
        bcnt      = 0;
        forever begin
            @(negedge clk);
            if (mif.Busy === 1'b1) begin
                bcnt++;
                if (bcnt == 1 && sb.size() > 0) begin
                    check({sb[0].name, " hold_hi"}, mif.HI, sb[0].old_hi);
                    check({sb[0].name, " hold_lo"}, mif.LO, sb[0].old_lo);
                end
            end else if (prev_busy && mif.Busy === 1'b0) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_busy_end: got busy cycles %0d expected none", bcnt);
                end else begin
                    e = sb.pop_front();
                    if (prev_rst) begin
                        $display("txn %s aborted by reset after %0d busy cycles", e.name, bcnt);
                    end else begin
                        check({e.name, " busy_cycles"}, 32'(bcnt), 32'(e.cycles));
                        check({e.name, " hi"}, mif.HI, e.hi);
                        check({e.name, " lo"}, mif.LO, e.lo);
                        $display("txn %s hi=%08h lo=%08h busy=%0d", e.name, mif.HI, mif.LO, bcnt);
                    end
                end
                bcnt = 0;
            end
            prev_busy = (mif.Busy === 1'b1);
            prev_rst  = reset;
        end
    end

    task automatic drive(input logic st, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        mif.Start = st;
        mif.MDUOp = op;
        mif.A     = a;
        mif.B     = b;
    endtask

    task automatic step(input logic st, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        drive(st, op, a, b);
        @(posedge clk);
        #1;
        drive(1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    task automatic wait_idle(input string nm);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mif.Busy === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s timeout: got busy after 40 cycles expected idle", nm);
        end
    endtask

    task automatic do_op(input string nm, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input int cyc);
        exp_t e;
        e.name = nm; e.hi = ehi; e.lo = elo; e.old_hi = m_hi; e.old_lo = m_lo; e.cycles = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        step(1'b1, op, a, b);
        wait_idle(nm);
        m_hi = ehi;
        m_lo = elo;
    endtask

    task automatic read_check(input string nm, input logic [3:0] op, input logic [31:0] exp);
        drive(1'b0, op, 32'hDEADBEEF, 32'hDEADBEEF);
        @(negedge clk);
        check(nm, mif.MDUOut, exp);
        $display("txn %s op=%0d out=%08h", nm, op, mif.MDUOut);
        drive(1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    initial begin
        exp_t e;
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset busy", {31'd0, mif.Busy}, 32'd0);
        check("reset hi", mif.HI, 32'd0);
        check("reset lo", mif.LO, 32'd0);

        // Preload HI/LO, read back, then reset clears them.
        @(posedge clk); #1;
        step(1'b0, 4'd7, 32'hAAAA5555, 32'd0);
        step(1'b0, 4'd8, 32'h00001234, 32'd0);
        read_check("mfhi preload", 4'd5, 32'hAAAA5555);
        read_check("mflo preload", 4'd6, 32'h00001234);
        read_check("mthi op out zero", 4'd7, 32'd0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("rst2 hi", mif.HI, 32'd0);
        check("rst2 lo", mif.LO, 32'd0);
        check("rst2 busy", {31'd0, mif.Busy}, 32'd0);

        do_op("mult -3*5", 4'd1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 5);
        do_op("multu ffffffff*2", 4'd2, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5);
        do_op("div -7/2", 4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        do_op("divu 7/2", 4'd4, 32'd7, 32'd2, 32'd1, 32'd3, 10);
        do_op("div ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10);

        @(posedge clk); #1;
        step(1'b0, 4'd7, 32'h12345678, 32'd0);
        m_hi = 32'h12345678;
        read_check("mfhi after mthi", 4'd5, 32'h12345678);
        do_op("divu by zero", 4'd4, 32'd99, 32'd0, 32'h12345678, 32'h80000000, 10);

        // Start with a non-arithmetic op must not start the unit.
        @(posedge clk); #1;
        step(1'b1, 4'd5, 32'd1, 32'd1);
        @(negedge clk);
        check("start mfhi ignored busy", {31'd0, mif.Busy}, 32'd0);
        check("start mfhi ignored hi", mif.HI, 32'h12345678);

        // A stray Start while busy must not disturb the running multiply.
        e.name = "mult 2*3 w/ stray start"; e.hi = 32'd0; e.lo = 32'd6;
        e.old_hi = m_hi; e.old_lo = m_lo; e.cycles = 5;
        sb.push_back(e);
        @(posedge clk); #1;
        step(1'b1, 4'd1, 32'd2, 32'd3);
        @(posedge clk); #1;
        step(1'b1, 4'd3, 32'd100, 32'd7);
        wait_idle("stray start");
        m_hi = 32'd0; m_lo = 32'd6;
        read_check("mflo after mult", 4'd6, 32'd6);

        // Abort a divide at its fourth busy cycle.
        e.name = "div abort"; e.hi = 32'd2; e.lo = 32'd14;
        e.old_hi = m_hi; e.old_lo = m_lo; e.cycles = 10;
        sb.push_back(e);
        @(posedge clk); #1;
        step(1'b1, 4'd3, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort busy", {31'd0, mif.Busy}, 32'd0);
        check("abort hi", mif.HI, 32'd0);
        check("abort lo", mif.LO, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("abort no late commit", mif.HI | mif.LO | {31'd0, mif.Busy}, 32'd0);
        end

        check("scoreboard empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Multiply/divide unit in the E stage, beside the ALU.
- Consumes the forwarded E-stage rs/rt operands and holds the architectural HI/LO registers.
- Executes mult, multu, div, divu over a fixed multi-cycle latency and raises Busy while doing so; the stall unit uses Busy to hold MDU instructions in D.
- Executes mfhi/mflo (combinational read into the E-stage result path) and mthi/mtlo (single-cycle write).

Parameters:
- MULT_CYCLES, 5, number of Busy cycles for mult/multu (must be ≥1).
- DIV_CYCLES, 10, number of Busy cycles for div/divu (must be ≥1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Start  input  1  one-cycle pulse, asserted while a mult/multu/div/divu occupies E.
- MDUOp  input  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9–15 none.
- A  input  32  forwarded rs value (FE_rs).
- B  input  32  forwarded rt value (FE_rt).
- Busy  output  1  high while a multi-cycle operation is in progress.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.
- MDUOut  output  32  combinational result: HI for mfhi, LO for mflo, 0 otherwise.

Behaviour:
- Reset (synchronous, highest priority): HI=0, LO=0, Busy=0, counter=0, shadow result registers=0. A reset during an operation aborts it; the pending result is discarded.
- FSM has two states, IDLE and RUN.
- IDLE:
  - On an edge with Start=1 and MDUOp in {1..4}: compute the result into shadow registers SH/SL, load counter with MULT_CYCLES or DIV_CYCLES, go to RUN.
  - Start with any other MDUOp: ignored.
- RUN:
  - Busy=1.
  - Counter decrements each edge.
  - On the edge where counter==1: HI<=SH, LO<=SL, Busy falls, go to IDLE.
- Timing: Start sampled at edge k gives Busy=1 for exactly N cycles after edge k. HI/LO change at edge k+N; Busy is 0 after that same edge.
- Stall interaction:
  - The stall unit must treat (Start | Busy) as "MDU occupied" and hold any MDU-class instruction in D.
  - Therefore Start never arrives while Busy=1. If it does, it is ignored and the current operation continues unaffected.
- mthi/mtlo:
  - Accepted only when Busy=0 and Start=0 (guaranteed by the stall unit).
  - HI<=A (mthi) or LO<=A (mtlo) at the next edge; no Busy.
- mfhi/mflo:
  - MDUOut reflects the current registered HI/LO.
  - The value is not forwarded from an in-flight shadow result; the stall guarantees this is never needed.
- Arithmetic:
  - mult: 64-bit signed product of A and B; HI=upper 32 bits, LO=lower 32 bits.
  - multu: same, unsigned.
  - div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Divide by zero (B==0 on div/divu): the full DIV_CYCLES Busy sequence still runs, but HI and LO keep their previous values.
- Signed overflow case: div 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- MDUOut is never X: it is 0 for every MDUOp other than 5 and 6.

Test Plan:
- Reset with HI/LO preloaded via mthi/mtlo, then reset=1 for one cycle → HI=0, LO=0, Busy=0 on the next cycle.
- mult A=0xFFFFFFFD (−3), B=5, Start at edge k → Busy=1 for cycles k+1..k+5; HI=0xFFFFFFFF and LO=0xFFFFFFF1 after edge k+5; HI/LO unchanged before that edge.
- multu A=0xFFFFFFFF, B=2 → HI=0x00000001, LO=0xFFFFFFFE after 5 Busy cycles.
- div A=0xFFFFFFF9 (−7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 Busy cycles. divu A=7, B=2 → LO=3, HI=1.
- mthi A=0x12345678, then mfhi in the next cycle → MDUOut=0x12345678. divu B=0 → Busy for 10 cycles, then HI/LO still 0x12345678 / previous LO.
- Start div, then assert reset at Busy cycle 4 → Busy=0, HI=LO=0 the next cycle; no late result commit in the following 10 cycles.
